// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and sizes for the display scheduler
//
// Purpose : FSM state enum, requester/data/counter widths and a one-hot
//           helper shared by display_scheduler and rr_pick4.
// Ports   : none (package).

package display_pkg;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational 4-way round-robin picker
//
// Purpose : pick the first active requester searching upward from
//           last_owner+1 (mod 4); last_owner itself is checked last so a
//           sole requester may win repeatedly.
// Ports   : req        in  4  request vector
//           last_owner in  2  index of the previous winner
//           any        out 1  at least one request is active
//           winner     out 2  selected index (last_owner when none active)

module rr_pick4
  import display_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last_owner,
  output logic               any,
  output logic [1:0]         winner
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    any    = |req;
    winner = last_owner;
    found  = 1'b0;
    idx    = last_owner;
    // offset 4 wraps to last_owner itself, which therefore has lowest priority
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = last_owner + 2'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - round-robin display arbiter with minimum dwell
//
// Purpose : grants one of four requesters the display for at least
//           DWELL_CYCLES cycles, forwarding the owner's value to the driver.
// Macro   : DISP_SCHED_PREEMPT_EN - requester 0 preempts any other owner.
// Ports   : disp_clk in  1   clock
//           rst_n    in  1   asynchronous active-low reset
//           req      in  4   level-sensitive requests
//           din_flat in  32  four signed bytes, requester i on [8i+7:8i]
//           ack      out 4   one-hot grant pulse
//           dout     out 8   signed value to display driver din
//           dout_en  out 1   load strobe to display driver en
//           owner    out 2   current or last owner
//           busy     out 1   high while in HOLD

module display_scheduler
  import display_pkg::*;
#(
  parameter logic [CNT_W-1:0] DWELL_CYCLES = 16'd50000
) (
  input  logic                     disp_clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*DATA_W-1:0] din_flat,
  output logic [NUM_REQ-1:0]       ack,
  output logic signed [DATA_W-1:0] dout,
  output logic                     dout_en,
  output logic [1:0]               owner,
  output logic                     busy
);

  state_e                     state_q, state_d;
  logic [NUM_REQ-1:0]         ack_q, ack_d;
  logic signed [DATA_W-1:0]   dout_q, dout_d;
  logic                       dout_en_q, dout_en_d;
  logic [1:0]                 owner_q, owner_d;
  logic [1:0]                 last_owner_q, last_owner_d;
  logic                       busy_q, busy_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  logic signed [DATA_W-1:0]   slice [NUM_REQ];
  logic                       pick_any;
  logic [1:0]                 pick_idx;
  logic                       grant;
  logic [1:0]                 grant_idx;
  logic                       preempt;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      slice[i] = din_flat[DATA_W*i +: DATA_W];
    end
  end

  rr_pick4 u_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .any        (pick_any),
    .winner     (pick_idx)
  );

`ifdef DISP_SCHED_PREEMPT_EN
  assign preempt = req[0] && (owner_q != 2'd0);
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ack_d        = '0;
    dout_d       = dout_q;
    dout_en_d    = 1'b0;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    grant        = 1'b0;
    grant_idx    = pick_idx;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) grant = 1'b1;
      end
      ST_HOLD: begin
        if (preempt) begin
          grant     = 1'b1;
          grant_idx = 2'd0;
        end else if (cnt_q == '0) begin
          // dwell expired: hand over back-to-back or fall idle
          if (pick_any) grant = 1'b1;
          else          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          // owner releasing req freezes dout but not the dwell
          if (req[owner_q] && (slice[owner_q] != dout_q)) begin
            dout_d    = slice[owner_q];
            dout_en_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant) begin
      state_d      = ST_HOLD;
      owner_d      = grant_idx;
      last_owner_d = grant_idx;
      dout_d       = slice[grant_idx];
      ack_d        = onehot4(grant_idx);
      dout_en_d    = 1'b1;
      cnt_d        = DWELL_CYCLES - CNT_W'(1);
    end

    busy_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge disp_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ack_q        <= '0;
      dout_q       <= '0;
      dout_en_q    <= 1'b0;
      owner_q      <= 2'd0;
      last_owner_q <= 2'd3;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      dout_q       <= dout_d;
      dout_en_q    <= dout_en_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ack     = ack_q;
  assign dout    = dout_q;
  assign dout_en = dout_en_q;
  assign owner   = owner_q;
  assign busy    = busy_q;

endmodule
